// File: rtl/mux2x32_dual_reg.sv
// mux2x32_dual_reg
//   2:1 datapath selector built twice: a behavioural conditional select and a
//   structural per-bit AND-OR network. Both results are visible combinationally.
//   The behavioural result is also captured in an enabled register. A registered
//   checker compares the two paths every cycle.
//
// Ports
//   clk             system clock; all state updates on the rising edge
//   rst             synchronous active-high reset
//   a, b            data inputs; a is selected when s=0, b when s=1
//   s               select
//   en              capture enable for y_q / s_q
//   y               behavioural result (combinational)
//   y_alt           structural result (combinational)
//   y_q, s_q        registered copies of y and s, loaded when en=1
//   mismatch        registered per-cycle flag: y != y_alt
//   mismatch_sticky set on any mismatch, cleared only by rst

// One bit of the structural path: (a & ~s) | (b & s), no conditional operator.
module mux2x32_dual_reg_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = (a & ~s) | (b & s);
endmodule

module mux2x32_dual_reg #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_alt,
    output logic [WIDTH-1:0] y_q,
    output logic             s_q,
    output logic             mismatch,
    output logic             mismatch_sticky
);

    logic [WIDTH-1:0] alt_w;
    logic [WIDTH-1:0] y_d;
    logic             s_d;

    // Behavioural path.
    always_comb begin
        y = s ? b : a;
    end

    // Structural path: one generated cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mux2x32_dual_reg_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .s (s),
            .y (alt_w[i])
        );
    end

    assign y_alt = alt_w;

    // Registered output: hold unless enabled.
    always_comb begin
        y_d = y_q;
        s_d = s_q;
        if (en) begin
            y_d = y;
            s_d = s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            s_q <= 1'b0;
        end else begin
            y_q <= y_d;
            s_q <= s_d;
        end
    end

    // Checker compares the y_alt output net itself, so a disturbance on that
    // net is what gets flagged. It samples every cycle regardless of en.
    if (CHECK_EN) begin : g_check
        logic mismatch_d;
        logic mismatch_q;
        logic sticky_d;
        logic sticky_q;

        always_comb begin
            mismatch_d = (y != y_alt);
            sticky_d   = sticky_q | mismatch_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mismatch_q <= 1'b0;
                sticky_q   <= 1'b0;
            end else begin
                mismatch_q <= mismatch_d;
                sticky_q   <= sticky_d;
            end
        end

        assign mismatch        = mismatch_q;
        assign mismatch_sticky = sticky_q;
    end else begin : g_nocheck
        assign mismatch        = 1'b0;
        assign mismatch_sticky = 1'b0;
    end

endmodule

// File: tb/tb_mux2x32_dual_reg.sv
// Directed bench for mux2x32_dual_reg: two instances share the stimulus, one
// with the checker enabled and one with it disabled.
module tb_mux2x32_dual_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        en;

    logic [31:0] y, y_alt, y_q;
    logic        s_q, mismatch, mismatch_sticky;
    logic [31:0] y0, y_alt0, y_q0;
    logic        s_q0, mismatch0, mismatch_sticky0;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux2x32_dual_reg #(.WIDTH(32), .CHECK_EN(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .a               (a),
        .b               (b),
        .s               (s),
        .en              (en),
        .y               (y),
        .y_alt           (y_alt),
        .y_q             (y_q),
        .s_q             (s_q),
        .mismatch        (mismatch),
        .mismatch_sticky (mismatch_sticky)
    );

    mux2x32_dual_reg #(.WIDTH(32), .CHECK_EN(1'b0)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .a               (a),
        .b               (b),
        .s               (s),
        .en              (en),
        .y               (y0),
        .y_alt           (y_alt0),
        .y_q             (y_q0),
        .s_q             (s_q0),
        .mismatch        (mismatch0),
        .mismatch_sticky (mismatch_sticky0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] e;

        rst = 1'b1; en = 1'b0; a = '0; b = '0; s = 1'b0;
        tick();
        chk("reset_y_q",      y_q, 32'h0);
        chk("reset_s_q",      {31'b0, s_q}, 32'h0);
        chk("reset_mismatch", {31'b0, mismatch}, 32'h0);
        chk("reset_sticky",   {31'b0, mismatch_sticky}, 32'h0);
        rst = 1'b0;

        // Select B
        a = 32'h0000_008B; b = 32'h0000_005F; s = 1'b1; en = 1'b1;
        #1;
        chk("selb_y",     y,     32'h5F);
        chk("selb_y_alt", y_alt, 32'h5F);
        tick();
        chk("selb_y_q", y_q, 32'h5F);
        chk("selb_s_q", {31'b0, s_q}, 32'h1);

        // Select A: combinational change, no clock
        s = 1'b0;
        #1;
        chk("sela_y",      y,     32'h8B);
        chk("sela_y_alt",  y_alt, 32'h8B);
        chk("sela_y_q_nc", y_q,   32'h5F);
        tick();
        chk("sela_y_q",     y_q, 32'h8B);
        chk("sela_s_q",     {31'b0, s_q}, 32'h0);
        chk("sela_mismatch", {31'b0, mismatch}, 32'h0);

        // a == b for both s values
        a = 32'hA5A5_3C3C; b = 32'hA5A5_3C3C; s = 1'b0; #1;
        chk("aeqb_s0", y, 32'hA5A5_3C3C);
        s = 1'b1; #1;
        chk("aeqb_s1_alt", y_alt, 32'hA5A5_3C3C);

        // Reset with en high wins
        a = 32'hFFFF_FFFF; b = 32'h0; s = 1'b0; en = 1'b1; rst = 1'b1;
        #1;
        chk("rst_y", y, 32'hFFFF_FFFF);
        tick();
        chk("rst_y_q",    y_q, 32'h0);
        chk("rst_s_q",    {31'b0, s_q}, 32'h0);
        chk("rst_sticky", {31'b0, mismatch_sticky}, 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_release_y_q", y_q, 32'hFFFF_FFFF);

        // Enable hold
        a = 32'h8B; b = 32'h5F; s = 1'b1; en = 1'b1;
        tick();
        chk("hold_load", y_q, 32'h5F);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = k[0];
            a = 32'h1111_0000 + k;
            b = 32'h2222_0000 + k;
            tick();
            chk("hold_y_q", y_q, 32'h5F);
            chk("hold_s_q", {31'b0, s_q}, 32'h1);
            chk("hold_y", y, (k % 2 == 1) ? 32'h2222_0000 + k : 32'h1111_0000 + k);
        end
        a = 32'h0000_1234; b = 32'hDEAD_BEEF; s = 1'b0; en = 1'b1;
        tick();
        chk("hold_reenable", y_q, 32'h0000_1234);

        // Walking-ones sweep
        for (int i = 0; i < 32; i++) begin
            for (int sv = 0; sv < 2; sv++) begin
                w = 32'h1 << i;
                a = w; b = ~w; s = sv[0];
                e = (sv == 1) ? ~w : w;
                #1;
                chk("walk_y",     y,     e);
                chk("walk_y_alt", y_alt, e);
                tick();
                chk("walk_mismatch", {31'b0, mismatch}, 32'h0);
            end
        end
        chk("walk_sticky", {31'b0, mismatch_sticky}, 32'h0);

        // Fault injection on y_alt bit 7 for one sampled edge
        a = 32'h8B; b = 32'h5F; s = 1'b0; en = 1'b1;
        tick();
        force dut.y_alt  = 32'h0000_000B;
        force dut0.y_alt = 32'h0000_000B;
        tick();
        release dut.y_alt;
        release dut0.y_alt;
        chk("fault_mismatch",     {31'b0, mismatch}, 32'h1);
        chk("fault_sticky",       {31'b0, mismatch_sticky}, 32'h1);
        chk("fault_off_mismatch", {31'b0, mismatch0}, 32'h0);
        chk("fault_off_sticky",   {31'b0, mismatch_sticky0}, 32'h0);
        #1;
        chk("fault_released_alt", y_alt, 32'h8B);
        tick();
        chk("fault_mismatch_1cyc", {31'b0, mismatch}, 32'h0);
        chk("fault_sticky_held",   {31'b0, mismatch_sticky}, 32'h1);
        tick();
        chk("fault_sticky_held2",  {31'b0, mismatch_sticky}, 32'h1);
        chk("fault_off_sticky2",   {31'b0, mismatch_sticky0}, 32'h0);
        rst = 1'b1;
        tick();
        chk("fault_sticky_cleared", {31'b0, mismatch_sticky}, 32'h0);
        chk("fault_rst_y_q", y_q, 32'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
